// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI slave front-end that deserialises command frames, tracks read sequencing and shifts out read data
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter int TX_W      = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  input  logic [TX_W-1:0]   tx_data,
  input  logic              tx_valid,
  output logic              busy
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam int CW  = $clog2(DATA_W + 3);
  localparam int TCW = $clog2(TX_W + 1);

  logic [2:0]        state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W+1:0] rx_sh;
  logic [DATA_W+1:0] rx_frame;
  logic              rd_addr_seen;
  logic              rx_done;
  logic              rx_ok;
  logic              last_bit;
  logic              cmd_ok;
  logic              tx_start;
  logic              tx_active;
  logic              tx_sent;
  logic [TX_W-1:0]   tx_sh;
  logic [TCW-1:0]    tx_cnt;

  assign busy = state != IDLE;

  // Frame completion, command legality and the single transmit launch, all decided at the sampling edge
  always_comb begin
    rx_frame = {rx_sh[DATA_W:0], MOSI};
    last_bit = !SS_n && (state == WRITE || state == READ_ADD || state == READ_DATA) &&
               !rx_done && bit_cnt == CW'(DATA_W + 1);
    cmd_ok   = state == READ_ADD  ? rx_frame[DATA_W+1:DATA_W] == 2'b10 :
               state == READ_DATA ? rx_frame[DATA_W+1:DATA_W] == 2'b11 : 1'b1;
    tx_start = !SS_n && state == READ_DATA && !tx_sent && tx_valid &&
               (rx_ok || (last_bit && cmd_ok));
  end

  // Receive FSM: command decode, payload shift-in, strobes and read-sequence tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_sh        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_done      <= 1'b0;
      rx_ok        <= 1'b0;
    end else begin
      rx_valid <= last_bit && cmd_ok;
      rx_err   <= last_bit && !cmd_ok;
      if (state == IDLE) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
        rx_done <= 1'b0;
        rx_ok   <= 1'b0;
        state   <= SS_n ? IDLE : CHK_CMD;
      end else if (SS_n) begin
        state <= IDLE;
      end else if (state == CHK_CMD) begin
        rx_sh   <= rx_frame;
        bit_cnt <= CW'(1);
        state   <= !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
      end else if (!rx_done) begin
        rx_sh   <= rx_frame;
        bit_cnt <= bit_cnt + CW'(1);
        if (last_bit) begin
          rx_done <= 1'b1;
          rx_ok   <= cmd_ok;
          if (cmd_ok) begin
            rx_data      <= rx_frame;
            rd_addr_seen <= state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : rd_addr_seen;
          end
        end
      end
    end
  end

  // Transmit shifter: one word per READ_DATA frame, dropped on deselect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO      <= 1'b0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
      tx_sent   <= 1'b0;
    end else if (state == IDLE || SS_n) begin
      MISO      <= 1'b0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
      tx_sent   <= 1'b0;
    end else if (tx_start) begin
      MISO      <= LSB_FIRST != 0 ? tx_data[0] : tx_data[TX_W-1];
      tx_sh     <= LSB_FIRST != 0 ? tx_data >> 1 : tx_data << 1;
      tx_cnt    <= TCW'(TX_W - 1);
      tx_active <= 1'b1;
      tx_sent   <= 1'b1;
    end else if (tx_active) begin
      MISO      <= tx_cnt == '0 ? 1'b0 : LSB_FIRST != 0 ? tx_sh[0] : tx_sh[TX_W-1];
      tx_sh     <= LSB_FIRST != 0 ? tx_sh >> 1 : tx_sh << 1;
      tx_cnt    <= tx_cnt == '0 ? tx_cnt : tx_cnt - TCW'(1);
      tx_active <= tx_cnt != '0;
    end
  end
endmodule

// File: tb/tb_spi_slave_gen.sv
// tb_spi_slave_gen: scoreboard bench for spi_slave_gen, MSB-first and LSB-first instances side by side
module tb_spi_slave_gen;
  localparam int DW = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic tx_valid = 1'b0;
  logic [TW-1:0] tx_data = '0;
  logic miso_m, miso_l, busy_m, busy_l, rxv_m, rxv_l, rxe_m, rxe_l;
  logic [DW+1:0] rxd_m, rxd_l;

  int vectors = 0;
  int errors = 0;

  typedef struct {logic err; logic [DW+1:0] data;} rx_t;
  typedef struct {logic busy; logic mm; logic ml;} cy_t;
  rx_t rx_q[$];
  cy_t cy_q[$];
  bit rd_seen = 1'b0;
  logic [DW+1:0] last_data = '0;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(DW), .TX_W(TW), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_m),
    .rx_data(rxd_m), .rx_valid(rxv_m), .rx_err(rxe_m),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy_m)
  );

  spi_slave_gen #(.DATA_W(DW), .TX_W(TW), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_l),
    .rx_data(rxd_l), .rx_valid(rxv_l), .rx_err(rxe_l),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle busy/MISO expectations and strobe scoreboard, decoupled from stimulus
  always @(negedge clk) begin
    cy_t c;
    rx_t r;
    if (cy_q.size() != 0) begin
      c = cy_q.pop_front();
      check("busy_msb", busy_m, c.busy);
      check("busy_lsb", busy_l, c.busy);
      check("miso_msb", miso_m, c.mm);
      check("miso_lsb", miso_l, c.ml);
    end
    if (rxv_m || rxe_m || rxv_l || rxe_l) begin
      if (rx_q.size() == 0) check("unexpected_strobe", {rxv_m, rxe_m, rxv_l, rxe_l}, 0);
      else begin
        r = rx_q.pop_front();
        check("rx_valid_msb", rxv_m, !r.err);
        check("rx_err_msb", rxe_m, r.err);
        check("rx_valid_lsb", rxv_l, !r.err);
        check("rx_err_lsb", rxe_l, r.err);
        check("rx_data_msb", rxd_m, r.data);
        check("rx_data_lsb", rxd_l, r.data);
      end
    end
  end

  // One SPI frame: abort_n>=0 deselects after abort_n bits, e_tx is the first edge with tx_valid,
  // len is the last selected edge, rst_k>=0 asserts reset right after that edge
  task automatic frame(input logic [DW+1:0] f, input int abort_n, input int e_tx, input int len,
                       input logic [TW-1:0] w, input int rst_k);
    int last, t, gap;
    bit ok, is_rd, tx_go;
    cy_t c;
    last  = abort_n >= 0 ? abort_n : len;
    tx_go = 1'b0;
    t     = e_tx > DW + 2 ? e_tx : DW + 2;
    if (abort_n < 0) begin
      is_rd = f[DW+1] && rd_seen;
      ok    = !f[DW+1] ? 1'b1 : rd_seen ? f[DW+1:DW] == 2'b11 : f[DW+1:DW] == 2'b10;
      rx_q.push_back('{err: !ok, data: ok ? f : last_data});
      if (ok) begin
        last_data = f;
        if (f[DW+1]) rd_seen = !rd_seen;
      end
      tx_go = is_rd && ok;
    end
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      SS_n     = k > last;
      MOSI     = (k >= 1 && k <= DW + 2) ? f[DW+2-k] : 1'($urandom);
      tx_valid = k >= e_tx && k <= last;
      tx_data  = w;
      @(posedge clk);
      c.busy = k <= last;
      c.mm   = tx_go && k <= last && k >= t && k < t + TW ? w[TW-1-(k-t)] : 1'b0;
      c.ml   = tx_go && k <= last && k >= t && k < t + TW ? w[k-t] : 1'b0;
      cy_q.push_back(c);
      if (k == rst_k) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_miso_msb", miso_m, 0);
        check("rst_miso_lsb", miso_l, 0);
        check("rst_busy", busy_m, 0);
        check("rst_rx_valid", rxv_m, 0);
        check("rst_rx_data", rxd_m, 0);
        rd_seen   = 1'b0;
        last_data = '0;
        SS_n      = 1'b1;
        tx_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    gap = $urandom_range(0, 1);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      cy_q.push_back('{busy: 1'b0, mm: 1'b0, ml: 1'b0});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_miso", miso_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_rx_valid", rxv_m, 0);
    check("reset_rx_err", rxe_m, 0);
    check("reset_rx_data", rxd_m, 0);
    rst = 1'b0;
    frame(10'h0A5, -1, 99, 11, 8'h00, -1);
    frame(10'h2C3, -1, 99, 12, 8'h00, -1);
    frame(10'h3FF, -1, 10, 20, 8'hB4, -1);
    frame(10'h3FF, -1, 99, 11, 8'h00, -1);
    frame(10'h2C3, -1, 5, 11, 8'h5A, -1);
    frame(10'h3FF, -1, 4, 22, 8'hC9, -1);
    frame(10'h1AA, 5, 99, 11, 8'h00, -1);
    frame(10'h155, -1, 99, 11, 8'h00, -1);
    frame(10'h0F0, DW + 1, 99, 11, 8'h00, -1);
    frame(10'h0F0, 0, 99, 11, 8'h00, -1);
    frame(10'h2C3, -1, 99, 11, 8'h00, -1);
    frame(10'h3A0, -1, 10, 20, 8'hB4, 13);
    frame(10'h3A0, -1, 99, 11, 8'h00, -1);
    for (int i = 0; i < 150; i++)
      frame(10'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DW + 1)) : -1,
            $urandom_range(2, 16), $urandom_range(10, 22), 8'($urandom), -1);
    repeat (3) @(negedge clk);
    check("rx_queue_drained", rx_q.size(), 0);
    check("cycle_queue_drained", cy_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
